alu_ablaufsteuerung: RTL and testbench
======================================

# alu_ablaufsteuerung

Sequencer between the instruction control and the ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU operands and function code. It generates the ALU's `StartSignal` and `Schreibsignal` pulses with per-operation wait times, captures `Ergebnis`, and returns it over a second valid/ready handshake. Integer div/mod/sqrt complete on the ALU's done signals; all other operations use fixed latencies.

## Interface
- `LATENZ_EINFACH`, 1: wait cycles for single-step integer, shift, rotate, compare and bitwise ops.
- `LATENZ_FADD`, 8: wait cycles for add.s and sub.s.
- `LATENZ_FMUL`, 6: wait cycles for mul.s.
- `LATENZ_FSQRT`, 40: wait cycles for sqrt.s.
- `LATENZ_FDIV`, 40: wait cycles for div.s.
- `ZEITLIMIT`, 255: maximum wait cycles for a done-terminated op before the timeout error.
- `ZAEHLER_BREITE`, 8: wait counter width. Every latency parameter and `ZEITLIMIT` lies in 1..2^ZAEHLER_BREITE-1.
- `Clock` in 1: single clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `AuftragGueltig` in 1: request valid.
- `AuftragBereit` out 1: ready for a request.
- `AuftragFunktionsCode` in 6: requested ALU function code.
- `AuftragDaten1`, `AuftragDaten2` in 32: operands.
- `AluDaten1`, `AluDaten2` out 32: registered operands to the ALU.
- `AluFunktionsCode` out 6: registered function code to the ALU.
- `AluStart` out 1: drives the ALU `StartSignal`.
- `AluSchreiben` out 1: drives the ALU `Schreibsignal`.
- `AluErgebnis` in 32: ALU `Ergebnis`.
- `DivisionFertig` in 1: integer divider acknowledge.
- `WurzelFertig` in 1: integer sqrt done (level signal).
- `ErgebnisGueltig` out 1: result valid.
- `ErgebnisBereit` in 1: consumer ready.
- `ErgebnisDaten` out 32: captured result.
- `Fehler` out 1: qualifies the result as illegal-code or timeout; valid while `ErgebnisGueltig`=1.
- `Belegt` out 1: high in every state except LEERLAUF.

## Operation
- **States.** LEERLAUF, START, WARTEN, SCHREIBEN, ERFASSEN, AUSGABE.
- **LEERLAUF.**
  - `AuftragBereit`=1.
  - On `AuftragGueltig`=1, register the code and both operands into the `Alu*` outputs.
  - Load the wait counter and go to START.
  - An illegal code goes directly to AUSGABE with `ErgebnisDaten`=0 and `Fehler`=1. The ALU is never pulsed.
- **Operation classes**, by `FunktionsCode`[5] and [4:0]:
  - Integer 00011, 00100, 00101: done-terminated. 00011 waits for `WurzelFertig`; 00100 and 00101 wait for `DivisionFertig`.
  - Integer 00000-00010, 00110-01001, 10000-10101, 11000-11100: `LATENZ_EINFACH`.
  - Float 00000 and 00001: `LATENZ_FADD`.
  - Float 00010: `LATENZ_FMUL`.
  - Float 00011: `LATENZ_FSQRT`.
  - Float 00100: `LATENZ_FDIV`.
  - Every other code is illegal, including mod.s (float 00101).
- **START.** `AluStart`=1 for exactly one cycle, then go to WARTEN.
- **WARTEN, fixed latency.** Count down from W; after W cycles go to SCHREIBEN.
- **WARTEN, done-terminated.**
  - The block samples the selected done input every cycle, in every state, into a previous-value register.
  - Completion is a rising edge: sample 1 with previous sample 0. A level left high by an earlier op does not complete.
  - The edge may occur in any WARTEN cycle. The START-cycle sample only updates the previous value.
  - On completion go to SCHREIBEN.
  - After `ZEITLIMIT` WARTEN cycles without an edge, go to AUSGABE with `ErgebnisDaten`=0 and `Fehler`=1, without pulsing `AluSchreiben`.
- **SCHREIBEN.** `AluSchreiben`=1 for exactly one cycle, then go to ERFASSEN.
- **ERFASSEN.** Register `AluErgebnis` into `ErgebnisDaten`, set `Fehler`=0, go to AUSGABE.
- **AUSGABE.**
  - `ErgebnisGueltig`=1.
  - `ErgebnisDaten` and `Fehler` are held stable until `ErgebnisBereit`=1 is sampled, then go to LEERLAUF.
- **Operand stability.** `AluDaten1`, `AluDaten2` and `AluFunktionsCode` are stable from START through AUSGABE. They change only on acceptance.
- **Request input during a running op.** `AuftragGueltig` is ignored whenever `AuftragBereit`=0.
- **Reset, asynchronous and active-low, including mid-operation.** State goes to LEERLAUF and the counter is cleared. All outputs go to 0 except `AuftragBereit`, which is 1 once in LEERLAUF. Any in-flight ALU op is abandoned; no `AluSchreiben` follows.

## Timing
- **Cycle numbering.** Cycle 0 is the clock cycle following the acceptance edge.
- **Fixed latency W:**
  - `AluStart` in cycle 0.
  - WARTEN in cycles 1..W.
  - `AluSchreiben` in cycle W+1.
  - ERFASSEN in cycle W+2.
  - `ErgebnisGueltig` from cycle W+3.
- **Done-terminated, edge sampled at the end of cycle k:** `AluSchreiben` in cycle k+1, `ErgebnisGueltig` from cycle k+3.
- **Timeout.** `ErgebnisGueltig` with `Fehler` from cycle `ZEITLIMIT`+1.
- **Illegal code.** `ErgebnisGueltig` with `Fehler` in cycle 0.
- **Throughput.** `AuftragBereit` rises the cycle after the output handshake. There is no overlap between ops.
- **Output registration.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset.**
  - Stimulus: assert `Reset`=0 during WARTEN of a FADD op.
  - Required: all outputs 0 immediately (asynchronously), `AuftragBereit`=1 after release, no `AluSchreiben` pulse.
- **Integer add.**
  - Stimulus: code 000000, operands 5 and 7; model returns 12 on the `AluSchreiben` edge.
  - Required: `AluStart` in cycle 0, `AluSchreiben` in cycle 2, `ErgebnisGueltig` in cycle 4 with data 12 and `Fehler`=0.
- **Float multiply.**
  - Stimulus: code 100010, operands 0x40000000 and 0x40400000, `LATENZ_FMUL`=6.
  - Required: `AluSchreiben` in cycle 7, result 0x40C00000 valid from cycle 9.
- **Integer divide.**
  - Stimulus: code 000100 with `DivisionFertig` already high at acceptance, low in cycle 3, high in cycle 20.
  - Required: completion only on the cycle-20 edge, `AluSchreiben` in cycle 21.
- **Sqrt timeout.**
  - Stimulus: code 000011 with `ZEITLIMIT`=16 and `WurzelFertig` held low.
  - Required: `ErgebnisGueltig` with `Fehler`=1 and data 0 in cycle 17, no `AluSchreiben`.
- **Illegal code and backpressure.**
  - Stimulus: code 100101; `ErgebnisBereit` held low for 5 cycles.
  - Required: `Fehler`=1 from cycle 0, no `AluStart`, output held stable for 5 cycles, `AuftragBereit` one cycle after the handshake.

Source files
------------

// File: rtl/alu_ablaufsteuerung_if.sv
// Handshake and ALU bus bundle for the ALU sequencer.
// slave modport: sequencer side (accepts requests, drives the ALU and returns results).
// master modport: environment side (instruction control, ALU and result consumer).
interface alu_ablaufsteuerung_if;
  logic        AuftragGueltig;
  logic        AuftragBereit;
  logic [5:0]  AuftragFunktionsCode;
  logic [31:0] AuftragDaten1;
  logic [31:0] AuftragDaten2;
  logic [31:0] AluDaten1;
  logic [31:0] AluDaten2;
  logic [5:0]  AluFunktionsCode;
  logic        AluStart;
  logic        AluSchreiben;
  logic [31:0] AluErgebnis;
  logic        DivisionFertig;
  logic        WurzelFertig;
  logic        ErgebnisGueltig;
  logic        ErgebnisBereit;
  logic [31:0] ErgebnisDaten;
  logic        Fehler;
  logic        Belegt;

  modport slave (
    input  AuftragGueltig, AuftragFunktionsCode, AuftragDaten1, AuftragDaten2,
    input  AluErgebnis, DivisionFertig, WurzelFertig, ErgebnisBereit,
    output AuftragBereit, AluDaten1, AluDaten2, AluFunktionsCode, AluStart,
    output AluSchreiben, ErgebnisGueltig, ErgebnisDaten, Fehler, Belegt
  );

  modport master (
    output AuftragGueltig, AuftragFunktionsCode, AuftragDaten1, AuftragDaten2,
    output AluErgebnis, DivisionFertig, WurzelFertig, ErgebnisBereit,
    input  AuftragBereit, AluDaten1, AluDaten2, AluFunktionsCode, AluStart,
    input  AluSchreiben, ErgebnisGueltig, ErgebnisDaten, Fehler, Belegt
  );
endinterface

// File: rtl/alu_ablaufsteuerung.sv
// Sequencer between instruction control and the ALU: one op at a time, start/write pulses, result capture.
// Latency: fixed ops W+3 cycles to result valid; div/mod/sqrt complete on done rising edge (+3), or time out.
// Backpressure: request ready only when idle; result held stable until ErgebnisBereit is sampled high.
// Ports: Clock, Reset (async, active-low), bus (request in, ALU operands/pulses out, ALU result and done
// inputs, result handshake out, Fehler qualifies the result, Belegt high whenever not idle).
module alu_ablaufsteuerung #(
  parameter int LATENZ_EINFACH = 1,
  parameter int LATENZ_FADD    = 8,
  parameter int LATENZ_FMUL    = 6,
  parameter int LATENZ_FSQRT   = 40,
  parameter int LATENZ_FDIV    = 40,
  parameter int ZEITLIMIT      = 255,
  parameter int ZAEHLER_BREITE = 8
) (
  input logic                  Clock,
  input logic                  Reset,
  alu_ablaufsteuerung_if.slave bus
);

  localparam logic [ZAEHLER_BREITE-1:0] W_EINFACH = ZAEHLER_BREITE'(LATENZ_EINFACH);
  localparam logic [ZAEHLER_BREITE-1:0] W_FADD    = ZAEHLER_BREITE'(LATENZ_FADD);
  localparam logic [ZAEHLER_BREITE-1:0] W_FMUL    = ZAEHLER_BREITE'(LATENZ_FMUL);
  localparam logic [ZAEHLER_BREITE-1:0] W_FSQRT   = ZAEHLER_BREITE'(LATENZ_FSQRT);
  localparam logic [ZAEHLER_BREITE-1:0] W_FDIV    = ZAEHLER_BREITE'(LATENZ_FDIV);
  localparam logic [ZAEHLER_BREITE-1:0] W_LIMIT   = ZAEHLER_BREITE'(ZEITLIMIT);
  localparam logic [ZAEHLER_BREITE-1:0] EINS      = ZAEHLER_BREITE'(1);

  typedef enum logic [2:0] {
    LEERLAUF, START, WARTEN, SCHREIBEN, ERFASSEN, AUSGABE
  } zustand_t;

  // How an op terminates its WARTEN phase.
  typedef enum logic [1:0] {
    ART_FEST, ART_DIVISION, ART_WURZEL, ART_ILLEGAL
  } art_t;

  zustand_t                  zustand;
  art_t                      art;
  logic [ZAEHLER_BREITE-1:0] zaehler;
  logic                      division_vorher;
  logic                      wurzel_vorher;

  art_t                      neu_art;
  logic [ZAEHLER_BREITE-1:0] neu_wartezeit;
  logic                      fertig_flanke;

  // Classify the requested code; done-terminated ops load the timeout limit instead of a latency.
  always_comb begin
    neu_art       = ART_ILLEGAL;
    neu_wartezeit = W_EINFACH;
    if (!bus.AuftragFunktionsCode[5]) begin
      case (bus.AuftragFunktionsCode[4:0])
        5'd3: begin
          neu_art       = ART_WURZEL;
          neu_wartezeit = W_LIMIT;
        end
        5'd4, 5'd5: begin
          neu_art       = ART_DIVISION;
          neu_wartezeit = W_LIMIT;
        end
        5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9,
        5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28: begin
          neu_art       = ART_FEST;
          neu_wartezeit = W_EINFACH;
        end
        default: ;
      endcase
    end else begin
      case (bus.AuftragFunktionsCode[4:0])
        5'd0, 5'd1: begin
          neu_art       = ART_FEST;
          neu_wartezeit = W_FADD;
        end
        5'd2: begin
          neu_art       = ART_FEST;
          neu_wartezeit = W_FMUL;
        end
        5'd3: begin
          neu_art       = ART_FEST;
          neu_wartezeit = W_FSQRT;
        end
        5'd4: begin
          neu_art       = ART_FEST;
          neu_wartezeit = W_FDIV;
        end
        default: ;
      endcase
    end
  end

  // Only a fresh 0->1 transition completes; a level left high by an earlier op is not a completion.
  always_comb begin
    fertig_flanke = 1'b0;
    if (art == ART_DIVISION) fertig_flanke = bus.DivisionFertig & ~division_vorher;
    else if (art == ART_WURZEL) fertig_flanke = bus.WurzelFertig & ~wurzel_vorher;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zustand              <= LEERLAUF;
      art                  <= ART_FEST;
      zaehler              <= '0;
      division_vorher      <= 1'b0;
      wurzel_vorher        <= 1'b0;
      bus.AuftragBereit    <= 1'b0;
      bus.AluDaten1        <= '0;
      bus.AluDaten2        <= '0;
      bus.AluFunktionsCode <= '0;
      bus.AluStart         <= 1'b0;
      bus.AluSchreiben     <= 1'b0;
      bus.ErgebnisGueltig  <= 1'b0;
      bus.ErgebnisDaten    <= '0;
      bus.Fehler           <= 1'b0;
      bus.Belegt           <= 1'b0;
    end else begin
      // Done inputs are sampled every cycle so the START cycle primes the edge detector.
      division_vorher  <= bus.DivisionFertig;
      wurzel_vorher    <= bus.WurzelFertig;
      bus.AluStart     <= 1'b0;
      bus.AluSchreiben <= 1'b0;

      case (zustand)
        LEERLAUF: begin
          if (!bus.AuftragBereit) begin
            // First cycle after reset release: advertise readiness.
            bus.AuftragBereit <= 1'b1;
          end else if (bus.AuftragGueltig) begin
            bus.AluDaten1        <= bus.AuftragDaten1;
            bus.AluDaten2        <= bus.AuftragDaten2;
            bus.AluFunktionsCode <= bus.AuftragFunktionsCode;
            bus.AuftragBereit    <= 1'b0;
            bus.Belegt           <= 1'b1;
            bus.ErgebnisDaten    <= '0;
            art                  <= neu_art;
            zaehler              <= neu_wartezeit;
            if (neu_art == ART_ILLEGAL) begin
              // Never pulse the ALU; report the error straight away.
              bus.Fehler          <= 1'b1;
              bus.ErgebnisGueltig <= 1'b1;
              zustand             <= AUSGABE;
            end else begin
              bus.Fehler   <= 1'b0;
              bus.AluStart <= 1'b1;
              zustand      <= START;
            end
          end
        end

        START: zustand <= WARTEN;

        WARTEN: begin
          if (art == ART_FEST) begin
            if (zaehler <= EINS) begin
              bus.AluSchreiben <= 1'b1;
              zustand          <= SCHREIBEN;
            end else begin
              zaehler <= zaehler - EINS;
            end
          end else if (fertig_flanke) begin
            // A completion in the last allowed cycle still wins over the timeout.
            bus.AluSchreiben <= 1'b1;
            zustand          <= SCHREIBEN;
          end else if (zaehler <= EINS) begin
            bus.ErgebnisDaten   <= '0;
            bus.Fehler          <= 1'b1;
            bus.ErgebnisGueltig <= 1'b1;
            zustand             <= AUSGABE;
          end else begin
            zaehler <= zaehler - EINS;
          end
        end

        SCHREIBEN: zustand <= ERFASSEN;

        ERFASSEN: begin
          bus.ErgebnisDaten   <= bus.AluErgebnis;
          bus.Fehler          <= 1'b0;
          bus.ErgebnisGueltig <= 1'b1;
          zustand             <= AUSGABE;
        end

        AUSGABE: begin
          if (bus.ErgebnisBereit) begin
            bus.ErgebnisGueltig <= 1'b0;
            bus.AuftragBereit   <= 1'b1;
            bus.Belegt          <= 1'b0;
            zaehler             <= '0;
            zustand             <= LEERLAUF;
          end
        end

        default: zustand <= LEERLAUF;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ablaufsteuerung.sv
// Bench for alu_ablaufsteuerung: directed cases plus randomized ops checked against a cycle-level reference.
// Two instances: default ZEITLIMIT (255) and ZEITLIMIT=16 for timeout cases, selected by sel.
// The ALU itself is modelled as a registered function updated on AluSchreiben.
module tb_alu_ablaufsteuerung;

  localparam int MAXC = 300;

  bit          clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        auftrag_gueltig;
  logic [5:0]  auftrag_fc;
  logic [31:0] d1, d2;
  logic        division_fertig, wurzel_fertig, ergebnis_bereit;

  int n_tests = 0;
  int n_fail  = 0;

  initial forever #5 clk = ~clk;

  alu_ablaufsteuerung_if bus0 ();
  alu_ablaufsteuerung_if bus1 ();

  assign bus0.AuftragGueltig       = auftrag_gueltig & ~sel;
  assign bus1.AuftragGueltig       = auftrag_gueltig & sel;
  assign bus0.ErgebnisBereit       = ergebnis_bereit & ~sel;
  assign bus1.ErgebnisBereit       = ergebnis_bereit & sel;
  assign bus0.AuftragFunktionsCode = auftrag_fc;
  assign bus1.AuftragFunktionsCode = auftrag_fc;
  assign bus0.AuftragDaten1        = d1;
  assign bus1.AuftragDaten1        = d1;
  assign bus0.AuftragDaten2        = d2;
  assign bus1.AuftragDaten2        = d2;
  assign bus0.DivisionFertig       = division_fertig;
  assign bus1.DivisionFertig       = division_fertig;
  assign bus0.WurzelFertig         = wurzel_fertig;
  assign bus1.WurzelFertig         = wurzel_fertig;

  alu_ablaufsteuerung dut0 (.Clock(clk), .Reset(rst_n), .bus(bus0));
  alu_ablaufsteuerung #(.ZEITLIMIT(16)) dut1 (.Clock(clk), .Reset(rst_n), .bus(bus1));

  typedef struct packed {
    logic        bereit;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  fc;
    logic        start;
    logic        schreiben;
    logic        gueltig;
    logic [31:0] dat;
    logic        fehler;
    logic        belegt;
  } obs_t;

  obs_t o0, o1, o;
  assign o0 = {bus0.AuftragBereit, bus0.AluDaten1, bus0.AluDaten2, bus0.AluFunktionsCode, bus0.AluStart,
               bus0.AluSchreiben, bus0.ErgebnisGueltig, bus0.ErgebnisDaten, bus0.Fehler, bus0.Belegt};
  assign o1 = {bus1.AuftragBereit, bus1.AluDaten1, bus1.AluDaten2, bus1.AluFunktionsCode, bus1.AluStart,
               bus1.AluSchreiben, bus1.ErgebnisGueltig, bus1.ErgebnisDaten, bus1.Fehler, bus1.Belegt};
  assign o  = sel ? o1 : o0;

  // External ALU behaviour: integer add for code 0, 2.0*3.0 for the float multiply case, else a mix.
  function automatic logic [31:0] alu_ref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 6'h00) return a + b;
    if (c == 6'h22 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + {26'd0, c};
  endfunction

  always @(posedge clk) if (bus0.AluSchreiben) bus0.AluErgebnis <= alu_ref(bus0.AluFunktionsCode, bus0.AluDaten1, bus0.AluDaten2);
  always @(posedge clk) if (bus1.AluSchreiben) bus1.AluErgebnis <= alu_ref(bus1.AluFunktionsCode, bus1.AluDaten1, bus1.AluDaten2);

  // -1: illegal, 0: done-terminated, otherwise the fixed wait W.
  function automatic int ref_latency(input logic [5:0] c);
    logic [4:0] f;
    f = c[4:0];
    if (!c[5]) begin
      if (f inside {5'd3, 5'd4, 5'd5}) return 0;
      if (f inside {[5'd0:5'd2], [5'd6:5'd9], [5'd16:5'd21], [5'd24:5'd28]}) return 1;
      return -1;
    end
    case (f)
      5'd0, 5'd1: return 8;
      5'd2:       return 6;
      5'd3:       return 40;
      5'd4:       return 40;
      default:    return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive the done input the op listens to; the other one gets noise.
  task automatic set_done(input logic [5:0] fc, input bit v);
    division_fertig = 1'($urandom_range(0, 1));
    wurzel_fertig   = 1'($urandom_range(0, 1));
    if (fc == 6'h03) wurzel_fertig = v;
    else if (fc == 6'h04 || fc == 6'h05) division_fertig = v;
  endtask

  // Done waveform per cycle: init before 'drop', then 0 until 'rise', then 1. Call at a negedge while idle.
  task automatic run_op(input logic [5:0] fc, input logic [31:0] a, input logic [31:0] b,
                        input bit init, input int drop, input int rise, input int hold);
    int lat, zl, exp_sw, exp_valid, got_start, n_start, got_sw, n_sw, got_valid;
    bit exp_err, ops_ok, hold_ok;
    logic [31:0] exp_dat;
    logic [33:0] held;
    bit wave [0:MAXC];
    zl  = sel ? 16 : 255;
    lat = ref_latency(fc);
    for (int c = 0; c <= MAXC; c++) wave[c] = (c < drop) ? init : (c >= rise);
    exp_sw = -1; exp_err = 1'b1; exp_dat = '0; exp_valid = 0;
    if (lat > 0) begin
      exp_sw = lat + 1; exp_valid = lat + 3; exp_err = 1'b0; exp_dat = alu_ref(fc, a, b);
    end else if (lat == 0) begin
      exp_valid = zl + 1;
      for (int k = 1; k <= zl; k++) begin
        if (wave[k] && !wave[k-1]) begin
          exp_sw = k + 1; exp_valid = k + 3; exp_err = 1'b0; exp_dat = alu_ref(fc, a, b);
          break;
        end
      end
    end

    check("ready_idle", o.bereit, 1'b1);
    auftrag_gueltig = 1'b1; auftrag_fc = fc; d1 = a; d2 = b; ergebnis_bereit = 1'b0;
    set_done(fc, init);
    @(posedge clk);
    got_start = -1; n_start = 0; got_sw = -1; n_sw = 0; got_valid = -1; ops_ok = 1'b1;
    for (int c = 0; c <= MAXC && got_valid < 0; c++) begin
      @(negedge clk);
      auftrag_gueltig = 1'($urandom_range(0, 1));
      auftrag_fc = 6'($urandom); d1 = $urandom; d2 = $urandom;
      set_done(fc, wave[c]);
      if (c == 0) check("busy_c0", {o.bereit, o.belegt}, 2'b01);
      if (o.start) begin n_start++; if (got_start < 0) got_start = c; end
      if (o.schreiben) begin n_sw++; if (got_sw < 0) got_sw = c; end
      if ({o.fc, o.d1, o.d2} != {fc, a, b}) ops_ok = 1'b0;
      if (o.gueltig) got_valid = c;
    end
    check("start_cycle", got_start, (lat < 0) ? -1 : 0);
    check("start_count", n_start, (lat < 0) ? 0 : 1);
    check("write_cycle", got_sw, exp_sw);
    check("write_count", n_sw, (exp_sw < 0) ? 0 : 1);
    check("valid_cycle", got_valid, exp_valid);
    check("result", {o.fehler, o.dat}, {exp_err, exp_dat});
    check("operands_stable", ops_ok, 1'b1);
    held = {o.gueltig, o.fehler, o.dat};
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if ({o.gueltig, o.fehler, o.dat} != held || o.bereit) hold_ok = 1'b0;
    end
    check("hold_stable", hold_ok, 1'b1);
    ergebnis_bereit = 1'b1; auftrag_gueltig = 1'b0;
    @(negedge clk);
    check("ready_after", {o.bereit, o.belegt, o.gueltig}, 3'b100);
    ergebnis_bereit = 1'b0;
  endtask

  initial begin
    int n_wr;
    logic [5:0] rc;
    int rp;
    rst_n = 1'b0; sel = 1'b0; auftrag_gueltig = 1'b0; auftrag_fc = '0; d1 = '0; d2 = '0;
    division_fertig = 1'b0; wurzel_fertig = 1'b0; ergebnis_bereit = 1'b0;
    #12;
    check("reset_outputs", o, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {o.bereit, o.belegt}, 2'b10);

    run_op(6'h00, 32'd5, 32'd7, 1'b0, 0, 1000, 0);              // integer add
    run_op(6'h22, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, 1000, 0); // float multiply
    run_op(6'h04, 32'd100, 32'd7, 1'b1, 3, 20, 0);                // divide, stale level then edge
    run_op(6'h25, 32'd1, 32'd2, 1'b0, 0, 1000, 5);                // illegal code with backpressure
    sel = 1'b1;
    run_op(6'h03, 32'd81, 32'd0, 1'b0, 0, 1000, 0);               // sqrt timeout
    sel = 1'b0;

    // Reset during WARTEN of a float add: abandoned op, no write pulse afterwards.
    auftrag_gueltig = 1'b1; auftrag_fc = 6'h20; d1 = 32'h3F80_0000; d2 = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk); auftrag_gueltig = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", o, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midop_reset", {o.bereit, o.belegt}, 2'b10);
    n_wr = 0;
    repeat (15) begin
      @(negedge clk);
      if (o.schreiben || o.gueltig) n_wr++;
    end
    check("no_write_after_reset", n_wr, 0);

    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) != 0) rc = 6'($urandom);
      else begin
        rp = $urandom_range(0, 7);
        rc = (rp < 3) ? 6'(3 + rp) : 6'(32 + rp - 3);
      end
      run_op(rc, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
             $urandom_range(1, sel ? 20 : 40), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
